cache_bus_arb: RTL and testbench

//  Multi-cache memory bus. Round-robin arbitration among num_caches_p caches with
//  a per-transaction owner lock. Owner's request beats go to memory; read-response

---
 rtl/cache_bus_arb_if.sv | 34 +++
 rtl/cache_bus_arb.sv | 161 ++++++++++++++++
 tb/tb_cache_bus_arb.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_bus_arb_if.sv
// cache_bus_arb_if: cache-side and memory-side bus signals of the arbiter.
// master is the arbiter's view; slave is the caches-plus-memory view.
interface cache_bus_arb_if #(
    parameter int num_caches_p     = 2,
    parameter int dma_data_width_p = 2
);
    localparam int DW = 32 * dma_data_width_p;
    localparam int PW = 1 + 32 + DW;

    logic [num_caches_p-1:0]         cb_valid_i;
    logic [num_caches_p-1:0]         cb_yumi_o;
    logic [num_caches_p-1:0][PW-1:0] cb_pkt_i;
    logic                            mem_ready_i;
    logic                            mem_valid_o;
    logic                            mem_we_o;
    logic [31:0]                     mem_addr_o;
    logic [DW-1:0]                   mem_wdata_o;
    logic                            mem_valid_i;
    logic [DW-1:0]                   mem_data_i;
    logic [num_caches_p-1:0]         cb_valid_o;
    logic [DW-1:0]                   cb_data_o;

    modport master (
        input  cb_valid_i, cb_pkt_i, mem_ready_i, mem_valid_i, mem_data_i,
        output cb_yumi_o, mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output cb_valid_o, cb_data_o
    );

    modport slave (
        output cb_valid_i, cb_pkt_i, mem_ready_i, mem_valid_i, mem_data_i,
        input  cb_yumi_o, mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  cb_valid_o, cb_data_o
    );
endinterface

// File: rtl/cache_bus_arb.sv
// cache_bus_arb: round-robin owner-locked arbiter, N caches onto one memory port.
// The owner keeps the bus for one whole block; read responses go back to it only.
module cache_bus_arb #(
    parameter int num_caches_p      = 2,
    parameter int block_width_p     = 8,
    parameter int dma_data_width_p  = 2,
    parameter bit assert_spurious_p = 1'b1
) (
    input  logic            clk_i,
    input  logic            nreset_i,
    cache_bus_arb_if.master bus
);
    localparam int N     = num_caches_p;
    localparam int BEATS = block_width_p / dma_data_width_p;
    localparam int DW    = 32 * dma_data_width_p;
    localparam int GW    = (N > 1) ? $clog2(N) : 1;
    localparam int CW    = $clog2(BEATS + 1);

    localparam logic [CW-1:0] LAST_BEAT  = CW'(BEATS - 1);
    localparam logic [CW-1:0] ALL_BEATS  = CW'(BEATS);
    localparam logic [GW-1:0] LAST_CACHE = GW'(N - 1);

    if ((block_width_p % dma_data_width_p) != 0 ||
        block_width_p < dma_data_width_p) begin : g_bad_width
        $error("block_width_p must be a nonzero multiple of dma_data_width_p");
    end

    typedef struct packed {
        logic          we;
        logic [31:0]   addr;
        logic [DW-1:0] wdata;
    } pkt_t;

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [CW-1:0] tx_q, tx_d;
    logic [CW-1:0] rx_q, rx_d;
    logic          we_q, we_d;

    pkt_t          own_pkt;
    logic          own_valid;
    logic          cur_we;
    logic          yumi;
    logic          resp;
    logic          found;
    logic [GW-1:0] cand;

    // Next-state: arbitration in IDLE, beat/response counting while owned.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        we_d      = we_q;
        yumi      = 1'b0;
        resp      = 1'b0;
        found     = 1'b0;
        cand      = '0;
        own_pkt   = pkt_t'(bus.cb_pkt_i[grant_q]);
        own_valid = bus.cb_valid_i[grant_q];
        cur_we    = (tx_q == '0) ? own_pkt.we : we_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.cb_valid_i) begin
                    for (int k = 1; k <= N; k++) begin
                        cand = GW'((int'(last_q) + k) % N);
                        if (!found && bus.cb_valid_i[cand]) begin
                            found   = 1'b1;
                            grant_d = cand;
                        end
                    end
                    tx_d    = '0;
                    rx_d    = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                yumi = bus.mem_ready_i & own_valid;
                resp = bus.mem_valid_i & ~cur_we & (rx_q != ALL_BEATS);
                rx_d = rx_q + CW'(resp);
                if (yumi) begin
                    tx_d = tx_q + CW'(1);
                    if (tx_q == '0) we_d = own_pkt.we;
                    if (tx_q == LAST_BEAT) begin
                        if (cur_we || rx_d == ALL_BEATS) begin
                            state_d = IDLE;
                            last_d  = grant_q;
                        end else begin
                            state_d = RESP;
                        end
                    end
                end
            end
            RESP: begin
                resp = bus.mem_valid_i & (rx_q != ALL_BEATS);
                rx_d = rx_q + CW'(resp);
                if (resp && rx_q == LAST_BEAT) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: only the owner's beats reach memory, responses go to the owner.
    always_comb begin
        bus.cb_yumi_o   = '0;
        bus.mem_valid_o = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.cb_valid_o  = '0;
        if (state_q == XFER) begin
            bus.mem_valid_o        = own_valid;
            bus.mem_we_o           = own_pkt.we;
            bus.mem_addr_o         = own_pkt.addr;
            bus.mem_wdata_o        = own_pkt.wdata;
            bus.cb_yumi_o[grant_q] = yumi;
        end
        bus.cb_valid_o[grant_q] = resp;
    end

    assign bus.cb_data_o = bus.mem_data_i;

    // State registers; reset restarts priority at cache 0.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_CACHE;
            tx_q    <= '0;
            rx_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            we_q    <= we_d;
        end
    end

    // Protocol checks: block direction is fixed, responses only for reads.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (nreset_i) begin
            if (state_q == XFER && yumi && tx_q != '0)
                assert (own_pkt.we == we_q)
                else $error("beat direction changed mid-block");
            if (assert_spurious_p)
                assert (!(bus.mem_valid_i &&
                          (state_q == IDLE || (state_q == XFER && cur_we))))
                else $error("memory response with no read outstanding");
        end
    end
endmodule

// File: tb/tb_cache_bus_arb.sv
// tb_cache_bus_arb: randomized bench for cache_bus_arb against a
// transaction-level model of ownership, beat and response counting.
module tb_cache_bus_arb;
    localparam int N     = 2;
    localparam int BW    = 8;
    localparam int DMA   = 2;
    localparam int BEATS = BW / DMA;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [63:0] d;
    } beat_t;

    typedef struct packed {
        logic [1:0]  yumi;
        logic        mv;
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [1:0]  cbv;
        logic [63:0] cdata;
    } obs_t;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    cache_bus_arb_if #(.num_caches_p(N), .dma_data_width_p(DMA)) bus();

    cache_bus_arb #(
        .num_caches_p(N), .block_width_p(BW), .dma_data_width_p(DMA),
        .assert_spurious_p(1'b0)
    ) dut (
        .clk_i(clk), .nreset_i(nreset), .bus(bus.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    beat_t cq[N][$];
    int    resp_due[$];

    logic [N-1:0] vld_drv;
    beat_t        pkt_drv[N];
    logic         rdy_drv;
    logic         mv_drv;
    logic [63:0]  md_drv;

    int ready_mode = 0;
    int blk_lo = 0, blk_hi = -1;
    int stall_pct = 0;
    int auto_resp = 0;
    int resp_lat = 0;
    int spur = 0;

    int m_owner = -1;
    int m_last = N - 1;
    int m_sent = 0;
    int m_got = 0;
    bit m_wr = 1'b0;

    function automatic string fmt(obs_t o);
        return $sformatf("yumi=%b mv=%b we=%b addr=%h wd=%h cbv=%b cd=%h",
                         o.yumi, o.mv, o.we, o.addr, o.wdata, o.cbv, o.cdata);
    endfunction

    function automatic bit all_done();
        bit q_empty = 1'b1;
        for (int i = 0; i < N; i++) if (cq[i].size() != 0) q_empty = 1'b0;
        return q_empty && m_owner < 0 && resp_due.size() == 0;
    endfunction

    task automatic push_block(int c, bit we, logic [31:0] base);
        for (int b = 0; b < BEATS; b++) begin
            beat_t x;
            x.we   = we;
            x.addr = base + 32'(8 * b);
            x.d    = {$urandom, $urandom};
            cq[c].push_back(x);
        end
    endtask

    // Transaction-level model: one owner per block, picked by rotation.
    task automatic model_step(output obs_t e);
        e = '0;
        e.cdata = md_drv;
        if (m_owner < 0) begin
            if (vld_drv != '0) begin
                for (int k = 1; k <= N; k++) begin
                    int c = (m_last + k) % N;
                    if (m_owner < 0 && vld_drv[c]) m_owner = c;
                end
                m_sent = 0;
                m_got  = 0;
                m_wr   = cq[m_owner][0].we;
            end
        end else begin
            if (m_sent < BEATS) begin
                e.mv    = vld_drv[m_owner];
                e.we    = pkt_drv[m_owner].we;
                e.addr  = pkt_drv[m_owner].addr;
                e.wdata = pkt_drv[m_owner].d;
                if (rdy_drv && vld_drv[m_owner]) e.yumi[m_owner] = 1'b1;
            end
            if (mv_drv && !m_wr && m_got < BEATS) begin
                e.cbv[m_owner] = 1'b1;
                m_got++;
            end
            if (e.yumi != '0) begin
                m_sent++;
                void'(cq[m_owner].pop_front());
                if (auto_resp != 0 && !m_wr) begin
                    int d = cyc + ((resp_lat > 0) ? resp_lat
                                                  : int'($urandom_range(1, 3)));
                    if (resp_due.size() > 0 && resp_due[$] > d) d = resp_due[$];
                    resp_due.push_back(d);
                end
            end
            if (m_sent == BEATS && (m_wr || m_got == BEATS)) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    endtask

    task automatic tick(output obs_t a, output obs_t e);
        bit due;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            vld_drv[i] = (cq[i].size() > 0) &&
                         (int'($urandom_range(99)) >= stall_pct);
            pkt_drv[i] = (cq[i].size() > 0) ? cq[i][0] : '0;
        end
        case (ready_mode)
            0:       rdy_drv = 1'b1;
            1:       rdy_drv = (cyc % 2 == 0);
            2:       rdy_drv = ($urandom_range(3) != 0);
            default: rdy_drv = !(cyc >= blk_lo && cyc <= blk_hi);
        endcase
        due = resp_due.size() > 0 && resp_due[0] <= cyc;
        if (due) void'(resp_due.pop_front());
        mv_drv = due || ((m_owner < 0 || m_wr) &&
                 (spur == 2 || (spur == 1 && $urandom_range(1) == 1)));
        md_drv = {$urandom, $urandom};
        bus.cb_valid_i  = vld_drv;
        for (int i = 0; i < N; i++) bus.cb_pkt_i[i] = pkt_drv[i];
        bus.mem_ready_i = rdy_drv;
        bus.mem_valid_i = mv_drv;
        bus.mem_data_i  = md_drv;
        #1;
        a.yumi  = bus.cb_yumi_o;
        a.mv    = bus.mem_valid_o;
        a.we    = bus.mem_we_o;
        a.addr  = bus.mem_addr_o;
        a.wdata = bus.mem_wdata_o;
        a.cbv   = bus.cb_valid_o;
        a.cdata = bus.cb_data_o;
        model_step(e);
    endtask

    task automatic clear_inputs();
        bus.cb_valid_i  = '0;
        bus.cb_pkt_i    = '0;
        bus.mem_ready_i = 1'b0;
        bus.mem_valid_i = 1'b0;
        bus.mem_data_i  = '0;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        clear_inputs();
        for (int i = 0; i < N; i++) cq[i].delete();
        resp_due.delete();
        m_owner = -1;
        m_last  = N - 1;
        m_sent  = 0;
        m_got   = 0;
        m_wr    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        bus.cb_valid_i  = '1;
        bus.cb_pkt_i    = '1;
        bus.mem_ready_i = 1'b1;
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = '0;
        #12;
        checks++;
        if (bus.cb_yumi_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_yumi got=%b want=00", bus.cb_yumi_o);
        end
        checks++;
        if (bus.mem_valid_o !== 1'b0 || bus.mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem got mv=%b we=%b want 0 0",
                     bus.mem_valid_o, bus.mem_we_o);
        end
        checks++;
        if (bus.mem_addr_o !== 32'h0 || bus.mem_wdata_o !== 64'h0) begin
            errors++;
            $display("FAIL reset_addr got a=%h d=%h want 0",
                     bus.mem_addr_o, bus.mem_wdata_o);
        end
        checks++;
        if (bus.cb_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_cbv got=%b want=00", bus.cb_valid_o);
        end
        do_reset();
    endtask

    task automatic test_read_basic();
        obs_t a, e;
        int ny = 0, nv = 0;
        ready_mode = 0; stall_pct = 0; auto_resp = 1; resp_lat = 2; spur = 0;
        push_block(0, 1'b0, 32'h40);
        for (int n = 0; n < 40; n++) begin
            tick(a, e);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL read_basic cyc=%0d got {%s} want {%s}",
                         cyc, fmt(a), fmt(e));
            end
            if (a.yumi == 2'b01) ny++;
            if (a.cbv == 2'b01) nv++;
            if (all_done()) break;
        end
        checks++;
        if (!all_done() || ny != BEATS || nv != BEATS) begin
            errors++;
            $display("FAIL read_basic_counts got yumi=%0d resp=%0d want %0d %0d",
                     ny, nv, BEATS, BEATS);
        end
    endtask

    task automatic test_rr_writes();
        obs_t a, e;
        int seq[$];
        int last_g = -1;
        int n0 = 0, n1 = 0, both = 0;
        do_reset();
        ready_mode = 0; stall_pct = 0; auto_resp = 0; spur = 0;
        for (int b = 0; b < 3; b++) begin
            push_block(0, 1'b1, 32'h1000 + 32'(b * 32'h40));
            push_block(1, 1'b1, 32'h2000 + 32'(b * 32'h40));
        end
        for (int n = 0; n < 200; n++) begin
            tick(a, e);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL rr_writes cyc=%0d got {%s} want {%s}",
                         cyc, fmt(a), fmt(e));
            end
            if (a.yumi == 2'b11) both++;
            if (a.yumi[0]) n0++;
            if (a.yumi[1]) n1++;
            if (a.yumi == 2'b01 || a.yumi == 2'b10) begin
                int g = a.yumi[1] ? 1 : 0;
                if (g != last_g) seq.push_back(g);
                last_g = g;
            end
            if (all_done()) break;
        end
        checks++;
        if (both != 0 || n0 != 3 * BEATS || n1 != 3 * BEATS) begin
            errors++;
            $display("FAIL rr_counts got both=%0d n0=%0d n1=%0d want 0 %0d %0d",
                     both, n0, n1, 3 * BEATS, 3 * BEATS);
        end
        checks++;
        if (seq.size() != 6) begin
            errors++;
            $display("FAIL rr_order_len got=%0d want=6", seq.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (seq[k] != k % 2) begin
                    errors++;
                    $display("FAIL rr_order[%0d] got=%0d want=%0d", k, seq[k], k % 2);
                end
            end
        end
    endtask

    task automatic test_ready_toggle();
        obs_t a, e;
        int na = 0;
        ready_mode = 1; stall_pct = 0; auto_resp = 0; spur = 0;
        push_block(1, 1'b1, 32'h100);
        for (int n = 0; n < 40; n++) begin
            tick(a, e);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ready_toggle cyc=%0d got {%s} want {%s}",
                         cyc, fmt(a), fmt(e));
            end
            if (a.yumi != 2'b00) begin
                checks++;
                if (!rdy_drv || a.addr !== 32'h100 + 32'(8 * na)) begin
                    errors++;
                    $display("FAIL ready_toggle_beat got addr=%h rdy=%b want addr=%h rdy=1",
                             a.addr, rdy_drv, 32'h100 + 32'(8 * na));
                end
                na++;
            end
            if (all_done()) break;
        end
        checks++;
        if (na != BEATS) begin
            errors++;
            $display("FAIL ready_toggle_count got=%0d want=%0d", na, BEATS);
        end
    endtask

    task automatic test_overlap();
        obs_t a, e;
        int c0 = cyc + 1;
        int t_last = -1;
        int ny = 0;
        ready_mode = 3; blk_lo = c0 + 4; blk_hi = c0 + 5;
        stall_pct = 0; auto_resp = 0; spur = 0;
        for (int k = 3; k <= 6; k++) resp_due.push_back(c0 + k);
        push_block(0, 1'b0, 32'h200);
        for (int n = 0; n < 30; n++) begin
            tick(a, e);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL overlap cyc=%0d got {%s} want {%s}",
                         cyc, fmt(a), fmt(e));
            end
            if (a.yumi[0]) begin
                ny++;
                if (ny == BEATS) t_last = cyc;
            end
            if (all_done()) break;
        end
        checks++;
        if (t_last != c0 + 6) begin
            errors++;
            $display("FAIL overlap_last_beat got cyc=%0d want=%0d", t_last, c0 + 6);
        end
        push_block(1, 1'b1, 32'h300);
        for (int n = 0; n < 2; n++) begin
            tick(a, e);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL overlap_next cyc=%0d got {%s} want {%s}",
                         cyc, fmt(a), fmt(e));
            end
        end
        checks++;
        if (a.yumi !== 2'b10) begin
            errors++;
            $display("FAIL overlap_no_resp_state got yumi=%b want=10", a.yumi);
        end
        for (int n = 0; n < 20 && !all_done(); n++) begin
            tick(a, e);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL overlap_tail cyc=%0d got {%s} want {%s}",
                         cyc, fmt(a), fmt(e));
            end
        end
        blk_hi = -1;
    endtask

    task automatic test_spurious();
        obs_t a, e;
        ready_mode = 0; stall_pct = 0; auto_resp = 0; spur = 2;
        for (int n = 0; n < 6; n++) begin
            tick(a, e);
            checks++;
            if (a.cbv !== 2'b00 || !mv_drv) begin
                errors++;
                $display("FAIL spurious_idle got cbv=%b mvi=%b want cbv=00 mvi=1",
                         a.cbv, mv_drv);
            end
        end
        push_block(0, 1'b1, 32'h400);
        for (int n = 0; n < 20; n++) begin
            tick(a, e);
            checks++;
            if (a !== e || a.cbv !== 2'b00) begin
                errors++;
                $display("FAIL spurious_write cyc=%0d got {%s} want {%s}",
                         cyc, fmt(a), fmt(e));
            end
            if (all_done()) break;
        end
        spur = 0;
    endtask

    task automatic test_reset_mid();
        obs_t a, e;
        int c0 = cyc + 1;
        int ny = 0, nv = 0;
        ready_mode = 0; stall_pct = 0; auto_resp = 0; spur = 0;
        resp_due.push_back(c0 + 2);
        resp_due.push_back(c0 + 3);
        push_block(0, 1'b0, 32'h500);
        for (int n = 0; n < 6; n++) begin
            tick(a, e);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL reset_mid_pre cyc=%0d got {%s} want {%s}",
                         cyc, fmt(a), fmt(e));
            end
        end
        #2;
        nreset = 1'b0;
        bus.mem_valid_i = 1'b1;
        bus.cb_valid_i  = '1;
        bus.mem_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.cb_valid_o !== 2'b00 || bus.cb_yumi_o !== 2'b00 ||
            bus.mem_valid_o !== 1'b0 || bus.mem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_async got cbv=%b yumi=%b mv=%b addr=%h want 0",
                     bus.cb_valid_o, bus.cb_yumi_o, bus.mem_valid_o, bus.mem_addr_o);
        end
        do_reset();
        auto_resp = 1; resp_lat = 0;
        push_block(1, 1'b0, 32'h600);
        for (int n = 0; n < 40; n++) begin
            tick(a, e);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL reset_mid_post cyc=%0d got {%s} want {%s}",
                         cyc, fmt(a), fmt(e));
            end
            if (a.yumi == 2'b10) ny++;
            if (a.cbv == 2'b10) nv++;
            if (all_done()) break;
        end
        checks++;
        if (!all_done() || ny != BEATS || nv != BEATS) begin
            errors++;
            $display("FAIL reset_mid_counts got yumi=%0d resp=%0d want %0d %0d",
                     ny, nv, BEATS, BEATS);
        end
    endtask

    task automatic test_random();
        obs_t a, e;
        ready_mode = 2; stall_pct = 20; auto_resp = 1; resp_lat = 0; spur = 1;
        for (int b = 0; b < 6; b++) begin
            for (int c = 0; c < N; c++) begin
                push_block(c, 1'($urandom_range(1)), {$urandom_range(255), 8'h00} + 32'(c * 32'h10000));
            end
        end
        for (int n = 0; n < 3000; n++) begin
            tick(a, e);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL random cyc=%0d got {%s} want {%s}",
                         cyc, fmt(a), fmt(e));
            end
            if (all_done()) break;
        end
        checks++;
        if (!all_done()) begin
            errors++;
            $display("FAIL random_timeout owner=%0d sent=%0d got=%0d",
                     m_owner, m_sent, m_got);
        end
        spur = 0;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_read_basic();
        test_rr_writes();
        test_ready_toggle();
        test_overlap();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
